// File: rtl/mem_128x1_port_ctrl_if.sv
// rtl/mem_128x1_port_ctrl_if.sv - request/response bundle for the 128x1 memory port controller
interface mem_128x1_port_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [6:0] req_addr;
   logic       req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_data;

   // requester side: issues requests, consumes responses
   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   // controller side
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mem_128x1_port_ctrl.sv
// rtl/mem_128x1_port_ctrl.sv - request/response controller for a 128x1 two-port memory with clear sweep
module mem_128x1_port_ctrl #(
   parameter int   CLEAR_ON_RESET = 1,
   parameter logic CLEAR_VAL      = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset_n,
   mem_128x1_port_ctrl_if.slave bus,
   input  logic                 clear_start,
   output logic                 busy,
   output logic [6:0]           mem_R0_addr,
   output logic                 mem_R0_en,
   output logic                 mem_R0_clk,
   input  logic                 mem_R0_data,
   output logic [6:0]           mem_W0_addr,
   output logic                 mem_W0_en,
   output logic                 mem_W0_clk,
   output logic                 mem_W0_data
);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [6:0] r_clr_addr;

   // one read sits here between its accept cycle and its data-capture cycle
   logic       r_rd_pend;

   // 2-entry in-order response buffer
   logic [1:0] r_fifo;
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;

   logic [1:0] w_outstanding;
   logic       w_run;
   logic       w_clearing;
   logic       w_req_ready;
   logic       w_accept;
   logic       w_acc_wr;
   logic       w_acc_rd;
   logic       w_pop;

   // The memory ports run on the controller clock.
   assign mem_R0_clk = clock;
   assign mem_W0_clk = clock;

   // Reads in flight plus buffered responses; the pending read always has a
   // buffer slot reserved because reads are refused once this reaches 2.
   assign w_outstanding = {1'b0, r_rd_pend} + r_count;

   // Qualifying with reset_n keeps the memory strobes and req_ready low while
   // reset is held, even though the state register already reads CLEAR/RUN.
   assign w_run      = (r_state == ST_RUN)   && reset_n;
   assign w_clearing = (r_state == ST_CLEAR) && reset_n;

   // Writes never need a buffer slot, so they are never throttled in RUN.
   assign w_req_ready = w_run && (bus.req_write || (w_outstanding < 2'd2));
   assign w_accept    = bus.req_valid && w_req_ready;
   assign w_acc_wr    = w_accept && bus.req_write;
   assign w_acc_rd    = w_accept && !bus.req_write;
   assign w_pop       = (r_count != 2'd0) && bus.rsp_ready;

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RESET_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic: sweep, serve requests, or wait for in-flight reads
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_addr == 7'd127) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // a read accepted alongside clear_start still needs its response
            if (clear_start) begin
               if ((w_outstanding != 2'd0) || w_acc_rd) begin
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_state_nxt = ST_CLEAR;
               end
            end
         end
         ST_DRAIN: begin
            if (w_outstanding == 2'd0) begin
               w_state_nxt = ST_CLEAR;
            end
         end
         default: begin
            w_state_nxt = RESET_STATE;
         end
      endcase
   end

   // output logic: memory strobes, handshake and status
   always_comb begin
      mem_W0_en     = w_clearing || w_acc_wr;
      mem_W0_addr   = w_clearing ? r_clr_addr : bus.req_addr;
      mem_W0_data   = w_clearing ? CLEAR_VAL  : bus.req_wdata;
      mem_R0_en     = w_acc_rd;
      mem_R0_addr   = bus.req_addr;
      bus.req_ready = w_req_ready;
      bus.rsp_valid = (r_count != 2'd0);
      bus.rsp_data  = r_fifo[r_rd_ptr];
      busy          = (r_state != ST_RUN);
   end

   // sweep address: advances one location per CLEAR cycle, parked at 0 otherwise
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_clr_addr <= 7'd0;
      end else if (r_state == ST_CLEAR) begin
         r_clr_addr <= r_clr_addr + 7'd1;
      end else begin
         r_clr_addr <= 7'd0;
      end
   end

   // mark that memory read data arrives next cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_pend <= 1'b0;
      end else begin
         r_rd_pend <= w_acc_rd;
      end
   end

   // response buffer: capture read data, pop on consume, push and pop may coincide
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_fifo   <= 2'b00;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (r_rd_pend) begin
            r_fifo[r_wr_ptr] <= mem_R0_data;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, r_rd_pend} - {1'b0, w_pop};
      end
   end

endmodule
